avg_pool_engine: RTL and testbench
==================================

// Module: avg_pool_engine
// PURPOSE
//   Producer side of the pool_done / rf_enable handshake consumed by the data controller.
//   - Accepts a stream of activations.
//   - Averages each group of WIN consecutive samples into one pooled result.
//   - Presents each result with pool_done held high until the controller acknowledges it with rf_enable.
//   - Emits a one-cycle tile_done pulse after NUM_OUT results.
// PARAMETERS
//   DATA_WIDTH  16  signed activation / result width
//   WIN_LOG2    2   log2 of samples per window (WIN = 1<<WIN_LOG2)
//   NUM_OUT     8   pooled results per tile (>=1)
//   ADDR_WIDTH  11  width of input-activation address counter
// PORTS
//   clock      in   1           rising-edge clock
//   reset      in   1           asynchronous, active-low reset
//   start      in   1           begin tile; sampled only in IDLE
//   in_valid   in   1           in_data valid
//   in_data    in   DATA_WIDTH  signed activation
//   in_ready   out  1           engine accepts in_data this cycle
//   rf_enable  in   1           controller ack of current pooled result
//   pool_out   out  DATA_WIDTH  signed pooled result, stable while pool_done=1
//   pool_done  out  1           pooled result available (level, held until ack)
//   apool_addr out  ADDR_WIDTH  count of samples accepted this tile (input address)
//   out_count  out  8           results acknowledged this tile
//   busy       out  1           high in every state except IDLE
//   tile_done  out  1           one-cycle pulse at tile end
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; all outputs 0; accumulator and counters cleared.
//   States: IDLE, ACCUM, HOLD, DONE.
//   IDLE:
//     - start=1 -> ACCUM; clear acc, elem_cnt, apool_addr, out_count.
//     - Otherwise stay.
//   ACCUM:
//     - in_ready=1.
//     - Accept on in_valid&in_ready: acc += sign-extended in_data; apool_addr++; elem_cnt++.
//     - acc width = DATA_WIDTH+WIN_LOG2; no overflow is possible.
//     - On accepting the WIN-th sample: pool_out <= (acc+in_data)>>>WIN_LOG2, truncated to DATA_WIDTH.
//       The shift is arithmetic, so rounding is toward -inf.
//     - Same edge: pool_done<=1, acc/elem_cnt cleared, -> HOLD.
//     - pool_done therefore rises 1 cycle after the last sample handshake.
//     - rf_enable is ignored in ACCUM.
//   HOLD:
//     - in_ready=0; pool_out and pool_done held.
//     - rf_enable=1 sampled: pool_done<=0, out_count++.
//       Then -> DONE if out_count==NUM_OUT-1 (pre-increment), else -> ACCUM.
//     - rf_enable may be high on the same cycle pool_done first rises. It is only sampled
//       from HOLD, so the minimum high time of pool_done is 1 cycle.
//   DONE:
//     - tile_done=1 for exactly this cycle; -> IDLE.
//     - out_count and apool_addr retain final values until the next start.
//   General rules:
//     - start outside IDLE is ignored.
//     - in_valid outside ACCUM is ignored; no data is lost because in_ready=0 there.
//     - apool_addr wraps modulo 2^ADDR_WIDTH without affecting the FSM.
//     - Reset asserted mid-tile aborts immediately. pool_done drops asynchronously and no
//       tile_done is produced.
//     - Back-to-back: start sampled in IDLE the cycle after DONE begins a new tile.
// TESTING
//   1. Reset mid-HOLD -> pool_done, busy, out_count go to 0 without waiting for clock.
//      After release, start is required to resume.
//   2. WIN=4, samples 4,8,12,16 back-to-back.
//      -> pool_out=10, pool_done=1 one cycle after 4th accept; in_ready=0 until ack.
//   3. Samples -1,-2,-2,-2 -> sum=-7 -> pool_out=-2 (arithmetic shift, floor).
//   4. Hold rf_enable=0 for 20 cycles -> pool_done and pool_out stable throughout.
//      rf_enable=1 -> pool_done=0 next cycle, out_count=1.
//   5. NUM_OUT=8 full tile with random in_valid gaps.
//      -> exactly 8 pool_done/ack pairs, apool_addr=32, single tile_done pulse, then IDLE.
//   6. start pulsed during ACCUM and in_valid driven during HOLD -> no effect on counts or results.

Source files
------------

// File: rtl/avg_pool_engine_if.sv
// Activation stream in, pooled-result handshake out, between the pool engine and its controller.
interface avg_pool_engine_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_ready;
    logic                         rf_enable;
    logic signed [DATA_WIDTH-1:0] pool_out;
    logic                         pool_done;

    modport master (
        input  in_valid,
        input  in_data,
        input  rf_enable,
        output in_ready,
        output pool_out,
        output pool_done
    );

    modport slave (
        output in_valid,
        output in_data,
        output rf_enable,
        input  in_ready,
        input  pool_out,
        input  pool_done
    );
endinterface

// File: rtl/avg_pool_engine.sv
// Average-pooling engine: averages WIN-sample windows and hands each result to the
// data controller over the pool_done / rf_enable handshake; tile_done after NUM_OUT results.
module avg_pool_engine #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned WIN_LOG2   = 2,
    parameter int unsigned NUM_OUT    = 8,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    avg_pool_engine_if.master     bus,
    output logic [ADDR_WIDTH-1:0] apool_addr,
    output logic [7:0]            out_count,
    output logic                  busy,
    output logic                  tile_done
);

    localparam int unsigned WIN   = 1 << WIN_LOG2;
    localparam int unsigned ACC_W = DATA_WIDTH + WIN_LOG2;
    localparam int unsigned CNT_W = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         elem_q, elem_d;
    logic [ADDR_WIDTH-1:0]    addr_d;
    logic [7:0]               cnt_d;
    logic signed [DATA_WIDTH-1:0] pool_out_d;
    logic                     pool_done_d;
    logic                     in_ready_d;
    logic                     busy_d;
    logic                     tile_done_d;
    logic                     accept;
    logic signed [ACC_W-1:0]  sum;

    assign accept = bus.in_valid & bus.in_ready;
    assign sum    = acc_q + ACC_W'(bus.in_data);

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        elem_d      = elem_q;
        addr_d      = apool_addr;
        cnt_d       = out_count;
        pool_out_d  = bus.pool_out;
        pool_done_d = bus.pool_done;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    elem_d  = '0;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (accept) begin
                    addr_d = apool_addr + ADDR_WIDTH'(1);
                    if (elem_q == CNT_W'(WIN - 1)) begin
                        // Arithmetic shift floors toward -inf; the window mean always fits DATA_WIDTH.
                        pool_out_d  = DATA_WIDTH'(sum >>> WIN_LOG2);
                        pool_done_d = 1'b1;
                        acc_d       = '0;
                        elem_d      = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d  = sum;
                        elem_d = elem_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.rf_enable) begin
                    pool_done_d = 1'b0;
                    cnt_d       = out_count + 8'd1;
                    state_d     = (out_count == 8'(NUM_OUT - 1)) ? DONE : ACCUM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == ACCUM);
        busy_d      = (state_d != IDLE);
        tile_done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            elem_q        <= '0;
            apool_addr    <= '0;
            out_count     <= '0;
            bus.pool_out  <= '0;
            bus.pool_done <= 1'b0;
            bus.in_ready  <= 1'b0;
            busy          <= 1'b0;
            tile_done     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            elem_q        <= elem_d;
            apool_addr    <= addr_d;
            out_count     <= cnt_d;
            bus.pool_out  <= pool_out_d;
            bus.pool_done <= pool_done_d;
            bus.in_ready  <= in_ready_d;
            busy          <= busy_d;
            tile_done     <= tile_done_d;
        end
    end

endmodule

// File: tb/tb_avg_pool_engine.sv
// Directed bench for avg_pool_engine: WIN=4, NUM_OUT=8, hand-computed pooled results.
module tb_avg_pool_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] apool_addr;
    logic [7:0]  out_count;
    logic        busy;
    logic        tile_done;

    int checks = 0;
    int errors = 0;
    int td_pulses = 0;
    int pd_rises = 0;
    logic pd_prev = 1'b0;

    avg_pool_engine_if #(.DATA_WIDTH(16)) bus ();

    avg_pool_engine #(
        .DATA_WIDTH(16),
        .WIN_LOG2  (2),
        .NUM_OUT   (8),
        .ADDR_WIDTH(11)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .bus       (bus.master),
        .apool_addr(apool_addr),
        .out_count (out_count),
        .busy      (busy),
        .tile_done (tile_done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (tile_done) td_pulses++;
        if (bus.pool_done && !pd_prev) pd_rises++;
        pd_prev = bus.pool_done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one sample and waits (bounded) until it is accepted; in_valid is left high.
    task automatic push(input logic signed [15:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("push timeout", 32'(n), 0);
        tick();
    endtask

    initial begin
        int s;
        int exp_v;
        int gap;
        logic signed [15:0] d;

        reset         = 1'b0;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.rf_enable = 1'b0;
        #1;
        chk("reset pool_done", 32'(bus.pool_done), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset in_ready", 32'(bus.in_ready), 0);
        chk("reset out_count", 32'(out_count), 0);
        chk("reset apool_addr", 32'(apool_addr), 0);
        chk("reset tile_done", 32'(tile_done), 0);
        chk("reset pool_out", bus.pool_out, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("idle no start busy", 32'(busy), 0);

        // Result 1: 4,8,12,16 -> 10
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start busy", 32'(busy), 1);
        chk("start in_ready", 32'(bus.in_ready), 1);
        push(16'sd4);
        push(16'sd8);
        push(16'sd12);
        chk("pre-last pool_done", 32'(bus.pool_done), 0);
        push(16'sd16);
        bus.in_valid = 1'b0;
        chk("r1 pool_done", 32'(bus.pool_done), 1);
        chk("r1 pool_out", bus.pool_out, 10);
        chk("r1 in_ready", 32'(bus.in_ready), 0);
        chk("r1 apool_addr", 32'(apool_addr), 4);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold pool_done", 32'(bus.pool_done), 1);
            chk("hold pool_out", bus.pool_out, 10);
        end
        bus.rf_enable = 1'b1;
        tick();
        bus.rf_enable = 1'b0;
        chk("r1 ack pool_done", 32'(bus.pool_done), 0);
        chk("r1 ack out_count", 32'(out_count), 1);
        chk("r1 ack in_ready", 32'(bus.in_ready), 1);

        // start during ACCUM is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start in accum out_count", 32'(out_count), 1);
        chk("start in accum apool_addr", 32'(apool_addr), 4);
        chk("start in accum in_ready", 32'(bus.in_ready), 1);

        // Result 2: -1,-2,-2,-2 -> sum -7 -> floor -2
        push(-16'sd1);
        push(-16'sd2);
        push(-16'sd2);
        push(-16'sd2);
        chk("r2 pool_done", 32'(bus.pool_done), 1);
        chk("r2 pool_out", bus.pool_out, -2);
        bus.in_data = 16'sd100;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        chk("hold in_valid apool_addr", 32'(apool_addr), 8);
        chk("hold in_valid in_ready", 32'(bus.in_ready), 0);
        chk("hold in_valid pool_out", bus.pool_out, -2);
        bus.rf_enable = 1'b1;
        tick();
        bus.rf_enable = 1'b0;
        chk("r2 ack out_count", 32'(out_count), 2);

        // Result 3: rf_enable high through ACCUM and on the rising cycle of pool_done
        bus.rf_enable = 1'b1;
        push(16'sd1);
        push(16'sd2);
        push(16'sd3);
        push(16'sd4);
        bus.in_valid = 1'b0;
        chk("r3 pool_done", 32'(bus.pool_done), 1);
        chk("r3 pool_out", bus.pool_out, 2);
        chk("r3 out_count before ack", 32'(out_count), 2);
        tick();
        bus.rf_enable = 1'b0;
        chk("r3 min pulse pool_done", 32'(bus.pool_done), 0);
        chk("r3 ack out_count", 32'(out_count), 3);

        // Results 4..8: random data, random in_valid gaps and ack delays
        for (int r = 4; r <= 8; r++) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
                bus.in_valid = 1'b0;
                gap = int'($urandom_range(0, 3));
                repeat (gap) tick();
                d = 16'($urandom_range(0, 65535));
                s += int'(d);
                push(d);
            end
            bus.in_valid = 1'b0;
            exp_v = s >>> 2;
            chk("rand pool_done", 32'(bus.pool_done), 1);
            chk("rand pool_out", bus.pool_out, exp_v);
            gap = int'($urandom_range(0, 4));
            repeat (gap) tick();
            chk("rand hold pool_out", bus.pool_out, exp_v);
            bus.rf_enable = 1'b1;
            tick();
            bus.rf_enable = 1'b0;
            chk("rand ack pool_done", 32'(bus.pool_done), 0);
            chk("rand ack out_count", 32'(out_count), r);
            if (r == 8) begin
                chk("tile_done at end", 32'(tile_done), 1);
                chk("busy in done", 32'(busy), 1);
            end else begin
                chk("tile_done mid tile", 32'(tile_done), 0);
            end
        end
        tick();
        chk("post tile tile_done", 32'(tile_done), 0);
        chk("post tile busy", 32'(busy), 0);
        chk("post tile apool_addr", 32'(apool_addr), 32);
        chk("post tile out_count", 32'(out_count), 8);
        chk("tile_done pulses", td_pulses, 1);
        chk("pool_done rises", pd_rises, 8);
        repeat (3) tick();
        chk("idle retains apool_addr", 32'(apool_addr), 32);

        // Abort with reset in HOLD of a second result
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("new tile apool_addr", 32'(apool_addr), 0);
        chk("new tile out_count", 32'(out_count), 0);
        for (int k = 0; k < 4; k++) push(16'sd5);
        bus.in_valid  = 1'b0;
        bus.rf_enable = 1'b1;
        tick();
        bus.rf_enable = 1'b0;
        for (int k = 0; k < 4; k++) push(16'sd7);
        bus.in_valid = 1'b0;
        chk("abort pre pool_done", 32'(bus.pool_done), 1);
        chk("abort pre out_count", 32'(out_count), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset pool_done", 32'(bus.pool_done), 0);
        chk("async reset busy", 32'(busy), 0);
        chk("async reset out_count", 32'(out_count), 0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("after abort busy", 32'(busy), 0);
        chk("after abort in_ready", 32'(bus.in_ready), 0);
        chk("after abort tile_done pulses", td_pulses, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume busy", 32'(busy), 1);
        chk("resume in_ready", 32'(bus.in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
